// File: rtl/jt900h_bus_resp.sv
// TLCS-900H memory bus responder: on-chip dual-byte RAM plus req/ack external port, CPU stalled via cpu_cen.
// Optional WAIT timeout with bus_err pulse when JT900H_BUSRESP_TIMEOUT_EN is defined.
module jt900h_bus_resp #(
    parameter int          RAM_AW   = 12,
    parameter logic [23:0] RAM_BASE = 24'h004000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    output logic        cpu_cen,
    input  logic [23:0] bus_addr,
    input  logic [15:0] bus_din,
    input  logic [1:0]  bus_we,
    input  logic        bus_rd,
    output logic [15:0] bus_dout,
    output logic        ext_req,
    output logic [22:0] ext_addr,
    output logic [15:0] ext_din,
    output logic [1:0]  ext_we,
    input  logic        ext_ack,
    input  logic [15:0] ext_dout,
    output logic        bus_err
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    logic              ram_sel;
    logic              acc;
    logic              stall;
    logic [RAM_AW-1:0] ram_wa;
    logic              unused_addr_lsb;

    assign ram_sel         = (bus_addr[23:RAM_AW+1] == RAM_BASE[23:RAM_AW+1]);
    assign ram_wa          = bus_addr[RAM_AW:1];
    assign acc             = bus_rd | (|bus_we);
    assign unused_addr_lsb = bus_addr[0];

    state_t      state_q, state_d;
    logic        ext_req_q, ext_req_d;
    logic [22:0] ext_addr_q, ext_addr_d;
    logic [15:0] ext_din_q, ext_din_d;
    logic [1:0]  ext_we_q, ext_we_d;
    logic [15:0] rdata_q, rdata_d;
    logic        sel_q;
    logic [15:0] ram_dout_q;

    assign stall   = acc & ~ram_sel & (state_q != ST_DONE);
    assign cpu_cen = cen & ~stall;

    // Byte-lane RAM; read port runs every clk so data is ready before the next cen.
    logic [7:0] mem_lo [RAM_DEPTH];
    logic [7:0] mem_hi [RAM_DEPTH];

    always_ff @(posedge clk) begin
        ram_dout_q <= {mem_hi[ram_wa], mem_lo[ram_wa]};
        if (cen && ram_sel && bus_we[0]) begin
            mem_lo[ram_wa] <= bus_din[7:0];
        end
        if (cen && ram_sel && bus_we[1]) begin
            mem_hi[ram_wa] <= bus_din[15:8];
        end
    end

`ifdef JT900H_BUSRESP_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       bus_err_q, bus_err_d;
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ext_req_d  = ext_req_q;
        ext_addr_d = ext_addr_q;
        ext_din_d  = ext_din_q;
        ext_we_d   = ext_we_q;
        rdata_d    = rdata_q;
`ifdef JT900H_BUSRESP_TIMEOUT_EN
        cnt_d      = cnt_q;
        bus_err_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (acc && !ram_sel) begin
                    ext_addr_d = bus_addr[23:1];
                    ext_we_d   = bus_we;
                    ext_din_d  = bus_din;
                    ext_req_d  = 1'b1;
                    state_d    = ST_WAIT;
`ifdef JT900H_BUSRESP_TIMEOUT_EN
                    cnt_d      = 8'd0;
`endif
                end
            end
            ST_WAIT: begin
                if (ext_ack) begin
                    ext_req_d = 1'b0;
                    if (ext_we_q == 2'b00) begin
                        rdata_d = ext_dout;
                    end
                    state_d = ST_DONE;
                end
`ifdef JT900H_BUSRESP_TIMEOUT_EN
                // 255th WAIT clk without an ack gives up on the access
                else if (cnt_q == 8'hFE) begin
                    ext_req_d = 1'b0;
                    rdata_d   = 16'hFFFF;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            ST_DONE: begin
                if (cpu_cen) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ext_req_q  <= 1'b0;
            ext_addr_q <= 23'd0;
            ext_din_q  <= 16'd0;
            ext_we_q   <= 2'b00;
            rdata_q    <= 16'd0;
            sel_q      <= 1'b0;
`ifdef JT900H_BUSRESP_TIMEOUT_EN
            cnt_q      <= 8'd0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ext_req_q  <= ext_req_d;
            ext_addr_q <= ext_addr_d;
            ext_din_q  <= ext_din_d;
            ext_we_q   <= ext_we_d;
            rdata_q    <= rdata_d;
            sel_q      <= ram_sel;
`ifdef JT900H_BUSRESP_TIMEOUT_EN
            cnt_q      <= cnt_d;
            bus_err_q  <= bus_err_d;
`endif
        end
    end

    assign ext_req  = ext_req_q;
    assign ext_addr = ext_addr_q;
    assign ext_din  = ext_din_q;
    assign ext_we   = ext_we_q;
    assign bus_dout = sel_q ? ram_dout_q : rdata_q;

endmodule

// File: tb/tb_jt900h_bus_resp.sv
// Bench for jt900h_bus_resp: transaction-level model checked every clk plus directed literal checks.
module tb_jt900h_bus_resp;

    localparam logic [23:0] RAM_BASE = 24'h004000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        cpu_cen;
    logic [23:0] bus_addr;
    logic [15:0] bus_din;
    logic [1:0]  bus_we;
    logic        bus_rd;
    logic [15:0] bus_dout;
    logic        ext_req;
    logic [22:0] ext_addr;
    logic [15:0] ext_din;
    logic [1:0]  ext_we;
    logic        ext_ack;
    logic [15:0] ext_dout;
    logic        bus_err;

    jt900h_bus_resp #(.RAM_AW(12), .RAM_BASE(RAM_BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .cpu_cen  (cpu_cen),
        .bus_addr (bus_addr),
        .bus_din  (bus_din),
        .bus_we   (bus_we),
        .bus_rd   (bus_rd),
        .bus_dout (bus_dout),
        .ext_req  (ext_req),
        .ext_addr (ext_addr),
        .ext_din  (ext_din),
        .ext_we   (ext_we),
        .ext_ack  (ext_ack),
        .ext_dout (ext_dout),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_ram(input logic [23:0] a);
        return (a >> 13) == (RAM_BASE >> 13);
    endfunction

    // Half-rate master enable
    initial begin
        cen = 1'b0;
        forever begin
            @(negedge clk);
            cen = ~cen;
        end
    end

    // External memory: acks ack_dly negedges after req rises, or on an explicit pulse request
    int          ack_dly = 0;
    logic [15:0] resp_data = 16'h0;
    int          pulse_req = 0;
    int          pulse_done = 0;
    int          req_age = 0;
    bit          acked = 1'b0;

    initial begin
        ext_ack  = 1'b0;
        ext_dout = 16'h0;
        forever begin
            @(negedge clk);
            ext_ack = 1'b0;
            if (pulse_req != pulse_done) begin
                pulse_done = pulse_req;
                ext_ack    = 1'b1;
                ext_dout   = resp_data;
            end else if (ext_req === 1'b1 && ack_dly > 0 && !acked) begin
                req_age++;
                if (req_age == ack_dly) begin
                    ext_ack  = 1'b1;
                    ext_dout = resp_data;
                    acked    = 1'b1;
                end
            end
            if (ext_req !== 1'b1) begin
                req_age = 0;
                acked   = 1'b0;
            end
        end
    end

    int   req_rises = 0;
    int   req_hi = 0;
    int   err_hi = 0;
    logic req_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (ext_req === 1'b1 && req_prev !== 1'b1) req_rises++;
            if (ext_req === 1'b1) req_hi++;
            if (bus_err === 1'b1) err_hi++;
            req_prev = ext_req;
        end
    end

    // Transaction-level model: memory image plus the outstanding external transaction
    logic [15:0] m_mem [4096];
    bit          m_known [4096];
    bit          m_pending = 1'b0;
    bit          m_completed = 1'b0;
    logic [22:0] m_addr;
    logic [1:0]  m_we;
    logic [15:0] m_din;
    logic [15:0] m_rdata;
    logic [15:0] m_dout;
    bit          m_dout_known = 1'b0;
    logic        m_err;
    int          m_wait = 0;

    always @(posedge clk) begin
        bit          acc;
        bit          sel;
        int          w;
        logic [15:0] old;
        bit          oldk;
        acc  = bus_rd || (bus_we != 2'b00);
        sel  = in_ram(bus_addr);
        w    = int'(bus_addr[12:1]);
        old  = m_mem[w];
        oldk = m_known[w];
        if (rst) begin
            m_pending    = 1'b0;
            m_completed  = 1'b0;
            m_addr       = 23'd0;
            m_we         = 2'b00;
            m_din        = 16'd0;
            m_rdata      = 16'd0;
            m_err        = 1'b0;
            m_dout       = 16'd0;
            m_dout_known = 1'b1;
        end else begin
            if (cen && sel && bus_we != 2'b00) begin
                m_mem[w]   = {bus_we[1] ? bus_din[15:8] : old[15:8],
                              bus_we[0] ? bus_din[7:0]  : old[7:0]};
                m_known[w] = oldk || (bus_we == 2'b11);
            end
            m_err = 1'b0;
            if (m_completed) begin
                if (cen) m_completed = 1'b0;
            end else if (m_pending) begin
                if (ext_ack) begin
                    m_pending   = 1'b0;
                    m_completed = 1'b1;
                    if (m_we == 2'b00) m_rdata = ext_dout;
                end
`ifdef JT900H_BUSRESP_TIMEOUT_EN
                else begin
                    m_wait++;
                    if (m_wait == 255) begin
                        m_pending   = 1'b0;
                        m_completed = 1'b1;
                        m_rdata     = 16'hFFFF;
                        m_err       = 1'b1;
                    end
                end
`endif
            end else if (acc && !sel) begin
                m_pending = 1'b1;
                m_wait    = 0;
                m_addr    = bus_addr[23:1];
                m_we      = bus_we;
                m_din     = bus_din;
            end
            if (sel) begin
                m_dout       = old;
                m_dout_known = oldk;
            end else begin
                m_dout       = m_rdata;
                m_dout_known = 1'b1;
            end
        end
    end

    bit chk_en = 1'b0;
    int gated = 0;

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("cpu_cen", cpu_cen,
                  cen & ~((bus_rd | (|bus_we)) & ~in_ram(bus_addr) & ~m_completed));
            check("ext_req", ext_req, m_pending);
            check("ext_addr", ext_addr, m_addr);
            check("ext_we", ext_we, m_we);
            check("ext_din", ext_din, m_din);
            check("bus_err", bus_err, m_err);
            if (m_dout_known) check("bus_dout", bus_dout, m_dout);
            if (cen && !cpu_cen) gated++;
        end
    end

    // One CPU bus cycle: present at a cen=0 edge, hold until consumed on a cen=1 edge with cpu_cen high
    task automatic cpu_access(input logic [23:0] a, input logic [1:0] we, input logic [15:0] din,
                              input logic rd, output logic [15:0] dout_seen, output int waits);
        bit done;
        @(negedge clk);
        #1;
        if (cen) begin
            @(negedge clk);
            #1;
        end
        bus_addr  = a;
        bus_we    = we;
        bus_din   = din;
        bus_rd    = rd;
        waits     = 0;
        done      = 1'b0;
        dout_seen = 16'hxxxx;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            #1;
            if (cpu_cen) begin
                dout_seen = bus_dout;
                done      = 1'b1;
            end else if (cen) begin
                waits++;
            end
        end
        if (!done) check("access_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus_we = 2'b00;
        bus_rd = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        int          w;
        int          r0;
        int          h0;
        int          e0;
        rst      = 1'b1;
        bus_addr = 24'h0;
        bus_din  = 16'h0;
        bus_we   = 2'b00;
        bus_rd   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_dout", bus_dout, 16'h0000);
        check("rst_ext_req", ext_req, 1'b0);
        check("rst_ext_addr", ext_addr, 23'h0);
        check("rst_ext_we", ext_we, 2'b00);
        check("rst_ext_din", ext_din, 16'h0000);
        check("rst_bus_err", bus_err, 1'b0);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // RAM word write then read
        cpu_access(24'h004010, 2'b11, 16'hA55A, 1'b0, d, w);
        check("ram_wr_waits", w, 0);
        cpu_access(24'h004010, 2'b00, 16'h0000, 1'b1, d, w);
        check("ram_rd_word", d, 16'hA55A);
        check("ram_rd_waits", w, 0);

        // Odd byte lane only
        cpu_access(24'h004010, 2'b11, 16'h1234, 1'b0, d, w);
        cpu_access(24'h004011, 2'b10, 16'h7700, 1'b0, d, w);
        cpu_access(24'h004010, 2'b00, 16'h0000, 1'b1, d, w);
        check("ram_lane_even_addr", d, 16'h7734);
        cpu_access(24'h004011, 2'b00, 16'h0000, 1'b1, d, w);
        check("ram_lane_odd_addr", d, 16'h7734);
        check("ram_never_gated", gated, 0);

        // External read, ack 3 clks after req
        ack_dly   = 3;
        resp_data = 16'hBEEF;
        r0        = req_rises;
        cpu_access(24'h200000, 2'b00, 16'h0000, 1'b1, d, w);
        check("ext_rd_data", d, 16'hBEEF);
        check("ext_rd_waits", w, 2);
        check("ext_rd_addr", ext_addr, 23'h100000);
        check("ext_rd_we", ext_we, 2'b00);
        check("ext_rd_nreq", req_rises - r0, 1);

        cpu_access(24'h004010, 2'b00, 16'h0000, 1'b1, d, w);
        check("ram_after_ext", d, 16'h7734);

        // External odd-byte write
        ack_dly   = 2;
        resp_data = 16'h0BAD;
        r0        = req_rises;
        cpu_access(24'h200003, 2'b10, 16'hCD00, 1'b0, d, w);
        check("ext_wr_we", ext_we, 2'b10);
        check("ext_wr_din", ext_din, 16'hCD00);
        check("ext_wr_addr", ext_addr, 23'h100001);
        check("ext_wr_nreq", req_rises - r0, 1);
        check("ext_wr_waits", w, 1);
        check("ext_wr_keeps_rdata", d, 16'hBEEF);

        // Reset while waiting, then a stray late ack
        ack_dly   = 0;
        resp_data = 16'h1111;
        r0        = req_rises;
        @(negedge clk);
        #1;
        bus_addr = 24'h200100;
        bus_rd   = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("wait_req_high", ext_req, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("rst_drops_req", ext_req, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        bus_rd = 1'b0;
        pulse_req++;
        repeat (4) @(negedge clk);
        #1;
        check("late_ack_req", ext_req, 1'b0);
        check("late_ack_dout", bus_dout, 16'h0000);
        check("late_ack_nreq", req_rises - r0, 1);

        // Normal operation resumes from IDLE
        ack_dly   = 2;
        resp_data = 16'h5A5A;
        cpu_access(24'h200100, 2'b00, 16'h0000, 1'b1, d, w);
        check("post_rst_rd", d, 16'h5A5A);

`ifdef JT900H_BUSRESP_TIMEOUT_EN
        ack_dly = 0;
        h0      = req_hi;
        e0      = err_hi;
        cpu_access(24'h300000, 2'b00, 16'h0000, 1'b1, d, w);
        check("tmo_data", d, 16'hFFFF);
        check("tmo_req_clks", req_hi - h0, 255);
        check("tmo_err_pulse", err_hi - e0, 1);
`else
        h0 = req_hi;
        e0 = err_hi;
        check("no_tmo_err", err_hi - e0, 0);
        check("no_tmo_req_idle", req_hi - h0, 0);
`endif

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
